// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Issues req/ack data-memory reads for loads, extracts/extends the result, and forwards ALU results otherwise.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memread_MEM,
    input  logic        regwrite_MEM,
    input  logic        load_unsigned_MEM,
    input  logic [3:0]  mask_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [31:0] ALU_data_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        regwrite_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] wb_data_WB,
    output logic        dmem_err
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                req_d;
    logic [DATA_W-1:0]   addr_d;
    logic [3:0]          be_d;
    logic                rw_d;
    logic [4:0]          rd_d;
    logic [DATA_W-1:0]   wb_d;
    logic                err_d;

    logic                mask_legal_c;
    logic                timeout_hit_c;
    logic [1:0]          lane_c;
    logic [DATA_W-1:0]   shifted_c;
    logic [DATA_W-1:0]   load_data_c;

    // Legal access shapes: single byte, aligned half, full word
    always_comb begin
        mask_legal_c = 1'b0;
        case (mask_MEM)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_legal_c = 1'b1;
            default:                   mask_legal_c = 1'b0;
        endcase
    end

    assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT - 1));

    assign stall_MEM = memread_MEM & mask_legal_c
                     & ~((state == S_WAIT) & (dmem_ack | timeout_hit_c));

    // Lane of the lowest enabled byte selects the shift amount
    always_comb begin
        lane_c = 2'd0;
        case (dmem_be)
            4'b0010:          lane_c = 2'd1;
            4'b0100, 4'b1100: lane_c = 2'd2;
            4'b1000:          lane_c = 2'd3;
            default:          lane_c = 2'd0;
        endcase
    end

    assign shifted_c = dmem_rdata >> {lane_c, 3'b000};

    always_comb begin
        load_data_c = shifted_c;
        case (dmem_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                load_data_c = {{24{~load_unsigned_MEM & shifted_c[7]}}, shifted_c[7:0]};
            4'b0011, 4'b1100:
                load_data_c = {{16{~load_unsigned_MEM & shifted_c[15]}}, shifted_c[15:0]};
            default:
                load_data_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            regwrite_WB <= 1'b0;
            rd_WB       <= '0;
            wb_data_WB  <= '0;
            dmem_err    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            dmem_req    <= req_d;
            dmem_addr   <= addr_d;
            dmem_be     <= be_d;
            regwrite_WB <= rw_d;
            rd_WB       <= rd_d;
            wb_data_WB  <= wb_d;
            dmem_err    <= err_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = dmem_req;
        addr_d  = dmem_addr;
        be_d    = dmem_be;
        rw_d    = regwrite_WB;
        rd_d    = rd_WB;
        wb_d    = wb_data_WB;
        err_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!memread_MEM) begin
                    rw_d = regwrite_MEM;
                    rd_d = rd_MEM;
                    wb_d = ALU_data_MEM;
                end else if (mask_legal_c) begin
                    addr_d  = {ALU_data_MEM[31:2], 2'b00};
                    be_d    = mask_MEM;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    rw_d    = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    err_d = 1'b1;
                    rw_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    wb_d    = load_data_c;
                    rw_d    = regwrite_MEM;
                    rd_d    = rd_MEM;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout_hit_c) begin
                    err_d   = 1'b1;
                    rw_d    = 1'b0;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                    rw_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (TIMEOUT=4).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memread_MEM, regwrite_MEM, load_unsigned_MEM;
    logic [3:0]  mask_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] ALU_data_MEM;
    logic        stall_MEM, dmem_req, dmem_ack, regwrite_WB, dmem_err;
    logic [31:0] dmem_addr, dmem_rdata, wb_data_WB;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_WB;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .memread_MEM(memread_MEM), .regwrite_MEM(regwrite_MEM),
        .load_unsigned_MEM(load_unsigned_MEM), .mask_MEM(mask_MEM),
        .rd_MEM(rd_MEM), .ALU_data_MEM(ALU_data_MEM),
        .stall_MEM(stall_MEM), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .wb_data_WB(wb_data_WB),
        .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic rw, input logic uns,
                         input logic [3:0] m, input logic [4:0] rd, input logic [31:0] d);
        memread_MEM = mr; regwrite_MEM = rw; load_unsigned_MEM = uns;
        mask_MEM = m; rd_MEM = rd; ALU_data_MEM = d;
        #1;
    endtask

    // Load that acks on WAIT cycle number 'ack_at' (1-based); checks stall every cycle
    task automatic do_load(input string tag, input logic [3:0] m, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input int ack_at, input logic [31:0] exp);
        drive(1'b1, 1'b1, uns, m, 5'd7, addr);
        check({tag, "_stall_idle"}, 32'(stall_MEM), 32'd1);
        for (int i = 1; i <= ack_at; i++) begin
            step();
            check({tag, "_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_rw_bubble"}, 32'(regwrite_WB), 32'd0);
            if (i == ack_at) begin
                dmem_rdata = rdata;
                dmem_ack   = 1'b1;
                #1;
                check({tag, "_stall_rel"}, 32'(stall_MEM), 32'd0);
            end else begin
                check({tag, "_stall_wait"}, 32'(stall_MEM), 32'd1);
            end
        end
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, 32'(dmem_be), 32'(m));
        step();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 5'd0, 32'd0);
        check({tag, "_rw"}, 32'(regwrite_WB), 32'd1);
        check({tag, "_rd"}, 32'(rd_WB), 32'd7);
        check({tag, "_data"}, wb_data_WB, exp);
        check({tag, "_req_off"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0);
        #12;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_rw", 32'(regwrite_WB), 32'd0);
        check("rst_wb", wb_data_WB, 32'd0);
        check("rst_err", 32'(dmem_err), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ALU op forwarding
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 5'd5, 32'h1234_5678);
        check("alu_stall", 32'(stall_MEM), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 5'd0, 32'd0);
        check("alu_rw", 32'(regwrite_WB), 32'd1);
        check("alu_rd", 32'(rd_WB), 32'd5);
        check("alu_data", wb_data_WB, 32'h1234_5678);
        check("alu_stall2", 32'(stall_MEM), 32'd0);

        do_load("lb",  4'b1000, 1'b0, 32'h0000_0103, 32'h80AA_BBCC, 1, 32'hFFFF_FF80);
        do_load("lhu", 4'b1100, 1'b1, 32'h0000_0042, 32'h8001_0000, 3, 32'h0000_8001);
        do_load("lh",  4'b0011, 1'b0, 32'h0000_0010, 32'h1234_F00D, 1, 32'hFFFF_F00D);
        do_load("lbu", 4'b0010, 1'b1, 32'h0000_0021, 32'h1234_F0CD, 2, 32'h0000_00F0);
        do_load("lb1", 4'b0100, 1'b0, 32'h0000_0022, 32'h1256_F0CD, 1, 32'h0000_0056);
        do_load("lw",  4'b1111, 1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);

        // Timeout: WAIT lasts 4 cycles, then error pulse
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 5'd3, 32'h0000_0200);
        check("to_stall_idle", 32'(stall_MEM), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_req", 32'(dmem_req), 32'd1);
            check("to_err_low", 32'(dmem_err), 32'd0);
            check("to_stall", 32'(stall_MEM), (i == 3) ? 32'd0 : 32'd1);
        end
        step();
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 5'd9, 32'h0000_CAFE);
        check("to_req_off", 32'(dmem_req), 32'd0);
        check("to_err", 32'(dmem_err), 32'd1);
        check("to_rw", 32'(regwrite_WB), 32'd0);
        check("to_next_stall", 32'(stall_MEM), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 5'd0, 32'd0);
        check("to_err_once", 32'(dmem_err), 32'd0);
        check("to_next_rw", 32'(regwrite_WB), 32'd1);
        check("to_next_rd", 32'(rd_WB), 32'd9);
        check("to_next_data", wb_data_WB, 32'h0000_CAFE);

        // Illegal mask
        drive(1'b1, 1'b1, 1'b0, 4'b0110, 5'd4, 32'h0000_0300);
        check("ill_stall", 32'(stall_MEM), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 5'd0, 32'd0);
        check("ill_req", 32'(dmem_req), 32'd0);
        check("ill_err", 32'(dmem_err), 32'd1);
        check("ill_rw", 32'(regwrite_WB), 32'd0);
        step();
        check("ill_err_once", 32'(dmem_err), 32'd0);

        // Reset while waiting; a later ack must be ignored
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 5'd6, 32'h0000_0400);
        step();
        check("mr_req", 32'(dmem_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mr_req_drop", 32'(dmem_req), 32'd0);
        check("mr_rw_drop", 32'(regwrite_WB), 32'd0);
        check("mr_stall", 32'(stall_MEM), 32'd1);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 5'd0, 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        check("mr_ack_req", 32'(dmem_req), 32'd0);
        check("mr_ack_rw", 32'(regwrite_WB), 32'd0);
        check("mr_ack_err", 32'(dmem_err), 32'd0);
        check("mr_ack_data", wb_data_WB, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
